// File: rtl/multicycle_control_fsm.sv
// Multi-cycle sequencer for the RV64 subset datapath (R-format, ld, sd, beq).
// Shares one memory port and one ALU across cycles; halts on illegal opcodes or memory timeouts.
module multicycle_control_fsm #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] Opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       PCSource,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemToReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [3:0] state,
  output logic       instr_done,
  output logic       illegal,
  output logic       bus_err
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXECUTE   = 4'd6,
    S_ALU_WB    = 4'd7,
    S_BRANCH    = 4'd8,
    S_HALT      = 4'd9
  } state_t;

  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_SD  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  localparam logic [1:0] SRCB_RS2 = 2'b00;
  localparam logic [1:0] SRCB_4   = 2'b01;
  localparam logic [1:0] SRCB_IMM = 2'b10;
  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_FN   = 2'b10;

  localparam bit             TO_EN   = (MEM_TIMEOUT != 0);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             illegal_q, bus_err_q;
  logic             illegal_set, bus_err_set;
  logic             wait_st, timeout;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    sat_inc = (&v) ? v : v + CNT_ONE;
  endfunction

  assign state   = state_q;
  assign illegal = illegal_q;
  assign bus_err = bus_err_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (illegal_set) illegal_q <= 1'b1;
      if (bus_err_set) bus_err_q <= 1'b1;
    end
  end

  assign wait_st = (state_q == S_FETCH) || (state_q == S_MEM_READ) || (state_q == S_MEM_WRITE);
  assign timeout = TO_EN && wait_st && !mem_ready && (cnt_q == TO_LAST);

  always_comb begin
    state_d     = state_q;
    illegal_set = 1'b0;
    bus_err_set = 1'b0;
    cnt_d       = '0;
    case (state_q)
      S_FETCH:     if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (Opcode)
          OP_LD, OP_SD: state_d = S_MEM_ADDR;
          OP_R:         state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          default: begin
            state_d     = S_HALT;
            illegal_set = 1'b1;
          end
        endcase
      end
      S_MEM_ADDR: begin
        // Opcode is held stable, so anything but ld/sd here means corrupted IR.
        if (Opcode == OP_LD)      state_d = S_MEM_READ;
        else if (Opcode == OP_SD) state_d = S_MEM_WRITE;
        else begin
          state_d     = S_HALT;
          illegal_set = 1'b1;
        end
      end
      S_MEM_READ:  if (mem_ready) state_d = S_MEM_WB;
      S_MEM_WB:    state_d = S_FETCH;
      S_MEM_WRITE: if (mem_ready) state_d = S_FETCH;
      S_EXECUTE:   state_d = S_ALU_WB;
      S_ALU_WB:    state_d = S_FETCH;
      S_BRANCH:    state_d = S_FETCH;
      S_HALT:      state_d = S_HALT;
      default: begin
        state_d     = S_HALT;
        illegal_set = 1'b1;
      end
    endcase
    if (timeout) begin
      state_d     = S_HALT;
      bus_err_set = 1'b1;
    end
    // Counter only accumulates consecutive stalls within a single visit to a memory state.
    if (wait_st && !mem_ready && (state_d == state_q)) cnt_d = sat_inc(cnt_q);
  end

  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    PCSource    = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemToReg    = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = SRCB_RS2;
    ALUOp       = ALU_ADD;
    instr_done  = 1'b0;
    // Reset gates every strobe so no write can land while rst_n is low.
    if (rst_n) begin
      case (state_q)
        S_FETCH: begin
          MemRead = 1'b1;
          ALUSrcB = SRCB_4;
          IRWrite = mem_ready;
          PCWrite = mem_ready;
        end
        S_DECODE:   ALUSrcB = SRCB_IMM;
        S_MEM_ADDR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = SRCB_IMM;
        end
        S_MEM_READ: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
        end
        S_MEM_WB: begin
          RegWrite   = 1'b1;
          MemToReg   = 1'b1;
          instr_done = 1'b1;
        end
        S_MEM_WRITE: begin
          MemWrite   = 1'b1;
          IorD       = 1'b1;
          instr_done = mem_ready;
        end
        S_EXECUTE: begin
          ALUSrcA = 1'b1;
          ALUOp   = ALU_FN;
        end
        S_ALU_WB: begin
          RegWrite   = 1'b1;
          instr_done = 1'b1;
        end
        S_BRANCH: begin
          ALUSrcA     = 1'b1;
          ALUOp       = ALU_SUB;
          PCWriteCond = 1'b1;
          PCSource    = 1'b1;
          instr_done  = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: per-instruction cycle scripts built from the
// instruction class and random memory stall counts, replayed against the DUT.
module tb_multicycle_control_fsm;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] Opcode = 7'd0;
  logic       mem_ready = 1'b0;
  logic       PCWrite, PCWriteCond, PCSource, IorD, MemRead, MemWrite, IRWrite;
  logic       MemToReg, RegWrite, ALUSrcA, instr_done, illegal, bus_err;
  logic [1:0] ALUSrcB, ALUOp;
  logic [3:0] state;

  always #5 clk = ~clk;

  multicycle_control_fsm #(.MEM_TIMEOUT(16), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .Opcode(Opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .PCSource(PCSource), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .MemToReg(MemToReg),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .state(state), .instr_done(instr_done), .illegal(illegal), .bus_err(bus_err)
  );

  logic [14:0] ctl;
  assign ctl = {PCWrite, PCWriteCond, PCSource, IorD, MemRead, MemWrite, IRWrite,
                MemToReg, RegWrite, ALUSrcA, ALUSrcB, ALUOp, instr_done};

  localparam logic [14:0] B_PCW   = 15'h4000;
  localparam logic [14:0] B_PCWC  = 15'h2000;
  localparam logic [14:0] B_PCS   = 15'h1000;
  localparam logic [14:0] B_IORD  = 15'h0800;
  localparam logic [14:0] B_MR    = 15'h0400;
  localparam logic [14:0] B_MW    = 15'h0200;
  localparam logic [14:0] B_IRW   = 15'h0100;
  localparam logic [14:0] B_M2R   = 15'h0080;
  localparam logic [14:0] B_RW    = 15'h0040;
  localparam logic [14:0] B_ASA   = 15'h0020;
  localparam logic [14:0] ASB_4   = 15'h0008;
  localparam logic [14:0] ASB_IMM = 15'h0010;
  localparam logic [14:0] OP_SUB  = 15'h0002;
  localparam logic [14:0] OP_FN   = 15'h0004;
  localparam logic [14:0] B_DONE  = 15'h0001;
  localparam logic [14:0] C_FW    = B_MR | ASB_4;

  localparam logic [6:0] LD  = 7'b0000011;
  localparam logic [6:0] SD  = 7'b0100011;
  localparam logic [6:0] RF  = 7'b0110011;
  localparam logic [6:0] BEQ = 7'b1100011;
  localparam logic [6:0] ILL = 7'b0010011;

  typedef struct {
    logic [6:0]  op;
    bit          rdy;
    logic [3:0]  st;
    logic [14:0] c;
    bit          ill;
    bit          berr;
  } step_t;

  step_t      q[$];
  step_t      s;
  bit         m_ill, m_berr;
  logic [6:0] cur_op;
  int         total = 0;
  int         passed = 0;

  function automatic bit rnd();
    return bit'($urandom_range(0, 1));
  endfunction

  task automatic push(input bit rdy, input logic [3:0] st, input logic [14:0] c);
    step_t e;
    e.op = cur_op; e.rdy = rdy; e.st = st; e.c = c; e.ill = m_ill; e.berr = m_berr;
    q.push_back(e);
  endtask

  task automatic model_fetch(input int w);
    repeat (w) push(1'b0, 4'd0, C_FW);
    push(1'b1, 4'd0, C_FW | B_IRW | B_PCW);
  endtask

  task automatic model_halt(input int n);
    repeat (n) push(rnd(), 4'd9, 15'h0);
  endtask

  // kind: 0=ld 1=sd 2=R-format 3=beq; wf/wm = stall cycles before mem_ready in fetch/memory
  task automatic model_instr(input int kind, input int wf, input int wm);
    case (kind)
      0: cur_op = LD;
      1: cur_op = SD;
      2: cur_op = RF;
      default: cur_op = BEQ;
    endcase
    model_fetch(wf);
    push(rnd(), 4'd1, ASB_IMM);
    case (kind)
      0: begin
        push(rnd(), 4'd2, B_ASA | ASB_IMM);
        repeat (wm) push(1'b0, 4'd3, B_MR | B_IORD);
        push(1'b1, 4'd3, B_MR | B_IORD);
        push(rnd(), 4'd4, B_RW | B_M2R | B_DONE);
      end
      1: begin
        push(rnd(), 4'd2, B_ASA | ASB_IMM);
        repeat (wm) push(1'b0, 4'd5, B_MW | B_IORD);
        push(1'b1, 4'd5, B_MW | B_IORD | B_DONE);
      end
      2: begin
        push(rnd(), 4'd6, B_ASA | OP_FN);
        push(rnd(), 4'd7, B_RW | B_DONE);
      end
      default: push(rnd(), 4'd8, B_ASA | OP_SUB | B_PCWC | B_PCS | B_DONE);
    endcase
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    mem_ready = rnd();
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_ill = 1'b0;
    m_berr = 1'b0;
    q.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mem_ready = 1'b1; Opcode = 7'($urandom);
    #1;
    total++;
    if (ctl !== 15'h0) $display("FAIL reset_comb: ctl=%h required 0000", ctl);
    else passed++;
    @(posedge clk); #1;
    total++;
    if ({state, illegal, bus_err} !== 6'b0) $display("FAIL reset_state: st=%0d ill=%b berr=%b required 0/0/0", state, illegal, bus_err);
    else passed++;
    total++;
    if (ctl !== 15'h0) $display("FAIL reset_hold: ctl=%h required 0000 while rst_n=0 in FETCH", ctl);
    else passed++;
    rst_n = 1'b1; m_ill = 1'b0; m_berr = 1'b0;
  endtask

  task automatic test_basic_instrs();
    int cyc;
    do_reset();
    for (int k = 0; k < 4; k++) model_instr(k, 0, 0);
    cyc = 0;
    while (q.size() > 0) begin
      s = q.pop_front(); Opcode = s.op; mem_ready = s.rdy; #1;
      total++;
      if ({state, ctl, illegal, bus_err} !== {s.st, s.c, s.ill, s.berr})
        $display("FAIL basic cyc%0d: st=%0d ctl=%h ill=%b berr=%b required st=%0d ctl=%h ill=%b berr=%b",
                 cyc, state, ctl, illegal, bus_err, s.st, s.c, s.ill, s.berr);
      else passed++;
      cyc++;
      @(posedge clk); #1;
    end
    // ld 5 + sd 4 + R 4 + beq 3 cycles, then back in FETCH
    total++;
    if (cyc != 16 || state !== 4'd0) $display("FAIL basic_latency: cycles=%0d st=%0d required 16/0", cyc, state);
    else passed++;
  endtask

  task automatic test_sd_wait();
    int mw_cnt, done_cnt;
    do_reset();
    model_instr(1, 0, 3);
    mw_cnt = 0; done_cnt = 0;
    while (q.size() > 0) begin
      s = q.pop_front(); Opcode = s.op; mem_ready = s.rdy; #1;
      total++;
      if ({state, ctl, illegal, bus_err} !== {s.st, s.c, s.ill, s.berr})
        $display("FAIL sd_wait: st=%0d ctl=%h required st=%0d ctl=%h", state, ctl, s.st, s.c);
      else passed++;
      if (MemWrite === 1'b1) mw_cnt++;
      if (instr_done === 1'b1) done_cnt++;
      @(posedge clk); #1;
    end
    total++;
    if (mw_cnt != 4 || done_cnt != 1 || state !== 4'd0)
      $display("FAIL sd_strobe: MemWrite cycles=%0d done=%0d st=%0d required 4/1/0", mw_cnt, done_cnt, state);
    else passed++;
  endtask

  task automatic test_illegal();
    do_reset();
    cur_op = ILL;
    model_fetch($urandom_range(0, 3));
    push(rnd(), 4'd1, ASB_IMM);
    m_ill = 1'b1;
    model_halt(22);
    while (q.size() > 0) begin
      s = q.pop_front(); Opcode = s.op; mem_ready = s.rdy; #1;
      total++;
      if ({state, ctl, illegal, bus_err} !== {s.st, s.c, s.ill, s.berr})
        $display("FAIL illegal: st=%0d ctl=%h ill=%b required st=%0d ctl=%h ill=%b", state, ctl, illegal, s.st, s.c, s.ill);
      else passed++;
      @(posedge clk); #1;
    end
    rst_n = 1'b0; mem_ready = 1'b1; #1;
    @(posedge clk); #1;
    total++;
    if ({state, illegal, bus_err} !== 6'b0) $display("FAIL illegal_clear: st=%0d ill=%b required 0/0", state, illegal);
    else passed++;
    rst_n = 1'b1;
  endtask

  task automatic test_fetch_timeout();
    do_reset();
    model_instr(3, 15, 0);
    cur_op = LD;
    repeat (16) push(1'b0, 4'd0, C_FW);
    m_berr = 1'b1;
    model_halt(20);
    while (q.size() > 0) begin
      s = q.pop_front(); Opcode = s.op; mem_ready = s.rdy; #1;
      total++;
      if ({state, ctl, illegal, bus_err} !== {s.st, s.c, s.ill, s.berr})
        $display("FAIL fetch_timeout: st=%0d ctl=%h berr=%b required st=%0d ctl=%h berr=%b", state, ctl, bus_err, s.st, s.c, s.berr);
      else passed++;
      @(posedge clk); #1;
    end
    rst_n = 1'b0; #1;
    @(posedge clk); #1;
    total++;
    if ({state, illegal, bus_err} !== 6'b0) $display("FAIL berr_clear: st=%0d berr=%b required 0/0", state, bus_err);
    else passed++;
    rst_n = 1'b1;
  endtask

  task automatic test_read_timeout();
    do_reset();
    cur_op = LD;
    model_fetch(0);
    push(rnd(), 4'd1, ASB_IMM);
    push(rnd(), 4'd2, B_ASA | ASB_IMM);
    repeat (16) push(1'b0, 4'd3, B_MR | B_IORD);
    m_berr = 1'b1;
    model_halt(5);
    while (q.size() > 0) begin
      s = q.pop_front(); Opcode = s.op; mem_ready = s.rdy; #1;
      total++;
      if ({state, ctl, illegal, bus_err} !== {s.st, s.c, s.ill, s.berr})
        $display("FAIL read_timeout: st=%0d ctl=%h berr=%b required st=%0d ctl=%h berr=%b", state, ctl, bus_err, s.st, s.c, s.berr);
      else passed++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_write();
    do_reset();
    cur_op = SD;
    model_fetch(0);
    push(rnd(), 4'd1, ASB_IMM);
    push(rnd(), 4'd2, B_ASA | ASB_IMM);
    push(1'b0, 4'd5, B_MW | B_IORD);
    while (q.size() > 0) begin
      s = q.pop_front(); Opcode = s.op; mem_ready = s.rdy; #1;
      total++;
      if ({state, ctl, illegal, bus_err} !== {s.st, s.c, s.ill, s.berr})
        $display("FAIL mid_write_setup: st=%0d ctl=%h required st=%0d ctl=%h", state, ctl, s.st, s.c);
      else passed++;
      @(posedge clk); #1;
    end
    mem_ready = 1'b0; rst_n = 1'b0; #1;
    total++;
    if (MemWrite !== 1'b0 || ctl !== 15'h0) $display("FAIL mid_write_abort: MemWrite=%b ctl=%h required 0/0000", MemWrite, ctl);
    else passed++;
    @(posedge clk); #1;
    total++;
    if ({state, illegal, bus_err} !== 6'b0) $display("FAIL mid_write_reset: st=%0d ill=%b berr=%b required 0/0/0", state, illegal, bus_err);
    else passed++;
    rst_n = 1'b1;
  endtask

  task automatic test_back_to_back();
    do_reset();
    repeat (40) model_instr($urandom_range(0, 3), $urandom_range(0, 6), $urandom_range(0, 6));
    while (q.size() > 0) begin
      s = q.pop_front(); Opcode = s.op; mem_ready = s.rdy; #1;
      total++;
      if ({state, ctl, illegal, bus_err} !== {s.st, s.c, s.ill, s.berr})
        $display("FAIL back_to_back op=%b: st=%0d ctl=%h required st=%0d ctl=%h", s.op, state, ctl, s.st, s.c);
      else passed++;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_basic_instrs();
    test_sd_wait();
    test_illegal();
    test_fetch_timeout();
    test_read_timeout();
    test_reset_mid_write();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
